mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  - Memory-side responder for the CPU's request/acknowledge memory bus: accepts read/write
//    requests from the core (initiator) and returns data with a programmable wait-state count.
//  - Holds a synchronous RAM array. Used as main memory in the CPU test bench.
//  - Also usable as an on-chip RAM in synthesis.
// PARAMETERS
//  ADDR_WIDTH    10  address bits; array depth = 2**ADDR_WIDTH words
//  DATA_WIDTH    8   word width
//  WAIT_STATES   2   cycles spent in WAIT before ack (0..15)
//  PROT_LIMIT    64  words [0, PROT_LIMIT) are write-protected (MEM_BUS_RESP_PROTECT_EN only)
// PORTS
//  master_clk  in   1           system clock, all state changes on rising edge
//  rst         in   1           asynchronous reset, active-high
//  req         in   1           initiator request, held high until ack
//  we          in   1           1 = write, 0 = read; stable while req high
//  addr        in   ADDR_WIDTH  word address; stable while req high
//  wdata       in   DATA_WIDTH  write data; stable while req high
//  rdata       out  DATA_WIDTH  read data, valid in ack cycle, held until next read ack
//  ack         out  1           one-cycle completion pulse
//  busy        out  1           high in WAIT and ACK states
//  err         out  1           one-cycle pulse with ack on a rejected write (PROTECT_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, wait counter=0, rdata=0, ack=0, busy=0, err=0.
//    RAM contents are not cleared.
//  - FSM states: IDLE, WAIT, ACK. All outputs are registered.
//  - IDLE: req=1 latches we/addr/wdata.
//    - WAIT_STATES=0: next state is ACK.
//    - WAIT_STATES>0: next state is WAIT, counter loaded to WAIT_STATES-1.
//  - WAIT: counter decrements each cycle; at 0, next state is ACK.
//    - req dropping to 0 in WAIT aborts: return to IDLE, no write, no ack.
//  - ACK: ack=1 for exactly one cycle, then return to IDLE unconditionally.
//    - Read: rdata = mem[latched addr] in the ack cycle.
//    - Write: mem[latched addr] <= latched wdata at the edge that enters ACK. rdata unchanged.
//  - Latency: req sampled at edge N gives ack high during cycle N+1+WAIT_STATES.
//  - Initiator drops req in the cycle after ack. If req is still 1 when IDLE samples it,
//    that is a new transaction (back-to-back, one idle cycle minimum between acks).
//  - Read-after-write to the same address in consecutive transactions returns the new data.
//  - Address wraps naturally; every addr value is in range, no decode error.
//  - Reset asserted mid-transaction: transaction dropped, no ack.
//    A write not yet in ACK does not update RAM.
// CONFIGURATION
//  MEM_BUS_RESP_PROTECT_EN defined:
//   - Write with latched addr < PROT_LIMIT: RAM not updated; ack and err pulse together.
//   - Reads are unaffected.
//  MEM_BUS_RESP_PROTECT_EN undefined:
//   - err tied to 0, no comparator is built, all writes commit.
// TESTING
//  1. Reset: hold rst=1 mid-WAIT -> ack=0, busy=0, rdata=0 immediately, without waiting for a clock edge.
//  2. Write addr=0x100 data=0xA5, then read 0x100 -> rdata=0xA5.
//     - Each ack arrives 3 cycles after req is sampled (WAIT_STATES=2).
//  3. WAIT_STATES=0, read back-to-back 0x101/0x102 with req held high -> ack pulses separated
//     by one idle cycle, correct data on each.
//  4. Abort: write 0x200=0x3C, drop req in WAIT; then read 0x200 -> old value, no ack for
//     the aborted write.
//  5. PROTECT_EN: write 0x010=0xFF -> ack=1 and err=1 in the same cycle; read 0x010 -> unchanged.
//     - Write 0x040=0xFF -> err=0, data commits.
//  6. Wrap: write addr=0x3FF then 0x000 with distinct data -> both read back correctly, no aliasing.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Request/ack memory responder with programmable wait states over a synchronous RAM.
// Define MEM_BUS_RESP_PROTECT_EN to write-protect words [0, PROT_LIMIT) and flag rejected writes on err.
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
`ifdef MEM_BUS_RESP_PROTECT_EN
  parameter int PROT_LIMIT  = 64,
`endif
  parameter int WAIT_STATES = 2
) (
  input  logic                  master_clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  txn_we;
  logic [ADDR_WIDTH-1:0] txn_addr;
  logic [DATA_WIDTH-1:0] txn_wdata;
  logic                  enter_ack;
  logic                  is_prot;
  logic                  commit;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states ACK is entered from IDLE, before the latches have loaded.
  assign txn_we    = (state == S_IDLE) ? we    : we_q;
  assign txn_addr  = (state == S_IDLE) ? addr  : addr_q;
  assign txn_wdata = (state == S_IDLE) ? wdata : wdata_q;
  assign enter_ack = (state_nxt == S_ACK);

`ifdef MEM_BUS_RESP_PROTECT_EN
  assign is_prot = (int'(txn_addr) < PROT_LIMIT);
`else
  assign is_prot = 1'b0;
`endif

  // Gating with rst keeps a write that races reset out of the array.
  assign commit = enter_ack & txn_we & ~is_prot & ~rst;

  always_ff @(posedge master_clk) begin
    if (commit) begin
      mem[txn_addr] <= txn_wdata;
    end
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack  <= enter_ack;
      busy <= (state_nxt != S_IDLE);
      err  <= enter_ack & txn_we & is_prot;
      if (enter_ack && !txn_we) begin
        rdata <= mem[txn_addr];
      end
      if (state == S_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder against an array-based reference model.
module tb_mem_bus_responder;

  localparam int WS = 2;
`ifdef MEM_BUS_RESP_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, req, req0, we;
  logic [9:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata, rdata0;
  logic       ack, busy, err, ack0, busy0, err0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [1024];
  bit         known   [1024];
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .WAIT_STATES(WS)) dut (
    .master_clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  mem_bus_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .master_clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_prot(input logic [9:0] a);
    return PROT_EN && (a < 10'd64);
  endfunction

  // One transaction on dut, entered and left at a negedge.
  task automatic txn(input bit w, input logic [9:0] a, input logic [7:0] d, input bit abort);
    int k;
    bit exp_err;
    we = w; addr = a; wdata = d; req = 1'b1;
    if (abort) begin
      @(negedge clk);
      check_eq("abort_busy", busy, 1);
      req = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check_eq("abort_noack", ack, 0);
      end
      check_eq("abort_idle", busy, 0);
      return;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!ack && k <= WS) check_eq("wait_busy", busy, 1);
    end while (!ack && k < 20);
    check_eq("latency", k, WS + 1);
    exp_err = w && is_prot(a);
    check_eq("err", err, exp_err);
    if (w) begin
      check_eq("wr_rdata_hold", rdata, last_rd);
      if (!exp_err) begin
        ref_mem[a] = d;
        known[a]   = 1'b1;
      end
    end else begin
      if (known[a]) begin
        check_eq("rd_data", rdata, ref_mem[a]);
      end else begin
        ref_mem[a] = rdata;   // first look at never-written power-up contents
        known[a]   = 1'b1;
      end
      last_rd = ref_mem[a];
    end
    req = 1'b0;
    @(negedge clk);
    check_eq("ack_pulse", ack, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         tw [4];
    logic [9:0] ta [4];
    logic [7:0] td [4];
    logic [9:0] pool [8];

    rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    last_rd = 8'h00;
    #1;
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_ack0", ack0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // write then read back
    txn(1'b1, 10'h100, 8'hA5, 1'b0);
    txn(1'b0, 10'h100, 8'h00, 1'b0);

    // abort in WAIT leaves old value
    txn(1'b1, 10'h200, 8'h11, 1'b0);
    txn(1'b1, 10'h200, 8'h3C, 1'b1);
    txn(1'b0, 10'h200, 8'h00, 1'b0);

    // address extremes
    txn(1'b1, 10'h3FF, 8'h5A, 1'b0);
    txn(1'b1, 10'h000, 8'hC3, 1'b0);
    txn(1'b0, 10'h3FF, 8'h00, 1'b0);
    txn(1'b0, 10'h000, 8'h00, 1'b0);

    // protected window edges
    txn(1'b0, 10'h010, 8'h00, 1'b0);
    txn(1'b1, 10'h010, 8'hFF, 1'b0);
    txn(1'b0, 10'h010, 8'h00, 1'b0);
    txn(1'b1, 10'h03F, 8'h99, 1'b0);
    txn(1'b1, 10'h040, 8'hFF, 1'b0);
    txn(1'b0, 10'h040, 8'h00, 1'b0);

    // reset mid-WAIT: outputs clear at once, pending write is lost
    txn(1'b0, 10'h100, 8'h00, 1'b0);
    we = 1'b1; addr = 10'h100; wdata = 8'h77; req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_ack", ack, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rdata", rdata, 0);
    last_rd = 8'h00;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(1'b1, 10'h300, 8'h42, 1'b0);
    txn(1'b0, 10'h100, 8'h00, 1'b0);

    // zero-wait-state instance, req held across four transactions
    tw = '{1'b1, 1'b1, 1'b0, 1'b0};
    ta = '{10'h101, 10'h102, 10'h101, 10'h102};
    td = '{8'h6B, 8'hD4, 8'h00, 8'h00};
    we = tw[0]; addr = ta[0]; wdata = td[0]; req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("b2b_ack", ack0, 1);
      check_eq("b2b_err", err0, 0);
      if (!tw[i]) check_eq("b2b_rdata", rdata0, (ta[i] == 10'h101) ? 8'h6B : 8'hD4);
      if (i < 3) begin
        we = tw[i+1]; addr = ta[i+1]; wdata = td[i+1];
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      check_eq("b2b_gap", ack0, 0);
      check_eq("b2b_gap_busy", busy0, 0);
    end

    // randomized traffic over a small address pool
    pool = '{10'h3FF, 10'h000, 10'h040, 10'h03F, 10'h100, 10'h200, 10'h155, 10'h2AA};
    for (int i = 6; i < 8; i++) pool[i] = 10'($urandom);
    for (int n = 0; n < 80; n++) begin
      logic [9:0] a;
      bit         w, ab;
      a  = pool[$urandom_range(0, 7)];
      w  = 1'($urandom_range(0, 1));
      ab = w && ($urandom_range(0, 7) == 0);
      txn(w, a, 8'($urandom), ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
